decoder_2to4_pipe: RTL

DECODER_2TO4_PIPE -- requirements
Module: decoder_2to4_pipe

---
 rtl/decoder_pkg.sv | 16 +
 rtl/code_fifo2.sv | 53 +++++
 rtl/decoder_2to4_pipe.sv | 94 +++++++++
 3 files changed

// File: rtl/decoder_pkg.sv
// rtl/decoder_pkg.sv - shared types and sizing for the pipelined 2-to-4 decoder
package decoder_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    DRIVE = 1'b1
  } state_t;

  localparam int FIFO_DEPTH = 2;
  localparam int HOLD_W     = 4;

  function automatic logic [3:0] onehot(input logic [1:0] code);
    onehot = 4'b0001 << code;
  endfunction

endpackage

// File: rtl/code_fifo2.sv
// rtl/code_fifo2.sv - two-entry in-order FIFO of 2-bit codes
module code_fifo2
  import decoder_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [1:0] wdata,
  output logic [1:0] rdata,
  output logic [1:0] count,
  output logic       full,
  output logic       empty
);

  localparam logic [1:0] DEPTH = 2'(FIFO_DEPTH);

  logic [1:0] mem [FIFO_DEPTH];
  logic       wr_ptr;
  logic       rd_ptr;
  logic       do_push;
  logic       do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];
  assign full    = (count == DEPTH);
  assign empty   = (count == 2'd0);

  // Storage needs no reset: the count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/decoder_2to4_pipe.sv
// rtl/decoder_2to4_pipe.sv - buffered 2-to-4 decoder holding each one-hot code for HOLD cycles
module decoder_2to4_pipe
  import decoder_pkg::*;
#(
  parameter int HOLD = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] d,
  input  logic       d_valid,
  output logic       d_ready,
  input  logic       en,
  output logic [3:0] o,
  output logic       o_valid,
  output logic       busy
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD - 1);

  state_t            state;
  state_t            state_nx;
  logic [HOLD_W-1:0] cnt;
  logic [HOLD_W-1:0] cnt_nx;
  logic [3:0]        code_q;
  logic [3:0]        code_nx;
  logic              pop;
  logic [1:0]        head;
  logic [1:0]        count;
  logic              full;
  logic              empty;

  code_fifo2 u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (d_valid && d_ready),
    .pop   (pop),
    .wdata (d),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // Ready depends only on the registered count, so a same-edge pop never widens it.
  assign d_ready = !full && !rst;
  assign busy    = (count != 2'd0) || (state != IDLE);
  assign o_valid = en && (state == DRIVE);
  assign o       = o_valid ? code_q : 4'b0000;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      code_q <= 4'b0000;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      code_q <= code_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    code_nx  = code_q;
    pop      = 1'b0;
    if (en) begin
      unique case (state)
        IDLE: begin
          if (!empty) begin
            pop      = 1'b1;
            state_nx = DRIVE;
            code_nx  = onehot(head);
            cnt_nx   = HOLD_LAST;
          end
        end
        DRIVE: begin
          if (cnt != '0) begin
            cnt_nx = cnt - HOLD_W'(1);
          end else if (!empty) begin
            pop     = 1'b1;
            code_nx = onehot(head);
            cnt_nx  = HOLD_LAST;
          end else begin
            state_nx = IDLE;
            code_nx  = 4'b0000;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

endmodule
